// File: rtl/text_vram_arbiter.sv
// Text-mode VRAM owner: one single-port RAM shared between the video character fetch,
// a CPU request/ack port and a clear-screen sequencer. Video always wins the slot.
module text_vram_arbiter #(
  parameter int COLS   = 80,
  parameter int ROWS   = 60,
  parameter int DATA_W = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [12:0]       vidPos,
  output logic [7:0]        character,
  output logic [2:0]        fgColor,
  output logic [2:0]        bgColor,
  input  logic              cpuReq,
  input  logic              cpuWe,
  input  logic [12:0]       cpuAddr,
  input  logic [DATA_W-1:0] cpuWData,
  output logic              cpuAck,
  output logic [DATA_W-1:0] cpuRData,
  input  logic              clrReq,
  input  logic [DATA_W-1:0] clrData,
  output logic              busy
);

  localparam logic [6:0] COL_LAST = 7'(COLS - 1);
  localparam logic [5:0] ROW_LAST = 6'(ROWS - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CPU_ACK = 2'd1,
    CLEAR   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [12:0]       last_pos_q, last_pos_d;
  logic [DATA_W-1:0] glyph_q, glyph_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic              cpu_rd_q, cpu_rd_d;
  logic              vid_pend_q, vid_pend_d;
  logic [DATA_W-1:0] clr_data_q, clr_data_d;
  logic [6:0]        clr_col_q, clr_col_d;
  logic [5:0]        clr_row_q, clr_row_d;

  logic [DATA_W-1:0] mem [0:8191];
  logic [DATA_W-1:0] ram_rdata_q;
  logic              rd_valid_q;
  logic              ram_en;
  logic              ram_we;
  logic [12:0]       ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_out;
  logic              video_fetch;

  function automatic logic in_range(input logic [12:0] a);
    return (a[12:6] <= COL_LAST) && (a[5:0] <= ROW_LAST);
  endfunction

  // Addresses outside the visible grid read as zero and are never written.
  assign ram_out     = rd_valid_q ? ram_rdata_q : '0;
  assign video_fetch = (vidPos != last_pos_q);

  always_comb begin
    state_d     = state_q;
    last_pos_d  = last_pos_q;
    glyph_d     = glyph_q;
    cpu_rdata_d = cpu_rdata_q;
    cpu_rd_d    = cpu_rd_q;
    clr_data_d  = clr_data_q;
    clr_col_d   = clr_col_q;
    clr_row_d   = clr_row_q;
    vid_pend_d  = video_fetch;
    ram_en      = 1'b0;
    ram_we      = 1'b0;
    ram_addr    = vidPos;
    ram_wdata   = clr_data_q;

    if (vid_pend_q) begin
      glyph_d = ram_out;
    end

    if (video_fetch) begin
      ram_en     = 1'b1;
      last_pos_d = vidPos;
    end

    case (state_q)
      IDLE: begin
        if (clrReq) begin
          state_d    = CLEAR;
          clr_data_d = clrData;
          clr_col_d  = '0;
          clr_row_d  = '0;
        end else if (cpuReq && !video_fetch) begin
          ram_en    = 1'b1;
          ram_addr  = cpuAddr;
          ram_we    = cpuWe && in_range(cpuAddr);
          ram_wdata = cpuWData;
          cpu_rd_d  = !cpuWe;
          state_d   = CPU_ACK;
        end
      end
      CPU_ACK: begin
        if (cpu_rd_q) begin
          cpu_rdata_d = ram_out;
        end
        state_d = IDLE;
      end
      CLEAR: begin
        if (!video_fetch) begin
          ram_en    = 1'b1;
          ram_we    = 1'b1;
          ram_addr  = {clr_col_q, clr_row_q};
          ram_wdata = clr_data_q;
          if (clr_row_q == ROW_LAST) begin
            clr_row_d = '0;
            if (clr_col_q == COL_LAST) begin
              state_d = IDLE;
            end else begin
              clr_col_d = clr_col_q + 7'd1;
            end
          end else begin
            clr_row_d = clr_row_q + 6'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A reset cycle must not disturb RAM contents, including a half-finished clear.
    if (reset) begin
      ram_we = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
    if (ram_en) begin
      ram_rdata_q <= mem[ram_addr];
      rd_valid_q  <= in_range(ram_addr);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      last_pos_q  <= 13'h1FFF;
      glyph_q     <= '0;
      cpu_rdata_q <= '0;
      cpu_rd_q    <= 1'b0;
      vid_pend_q  <= 1'b0;
      clr_data_q  <= '0;
      clr_col_q   <= '0;
      clr_row_q   <= '0;
    end else begin
      state_q     <= state_d;
      last_pos_q  <= last_pos_d;
      glyph_q     <= glyph_d;
      cpu_rdata_q <= cpu_rdata_d;
      cpu_rd_q    <= cpu_rd_d;
      vid_pend_q  <= vid_pend_d;
      clr_data_q  <= clr_data_d;
      clr_col_q   <= clr_col_d;
      clr_row_q   <= clr_row_d;
    end
  end

  assign character = glyph_q[DATA_W-1:6];
  assign fgColor   = glyph_q[5:3];
  assign bgColor   = glyph_q[2:0];
  assign cpuAck    = (state_q == CPU_ACK) && !reset;
  assign cpuRData  = (state_q == CPU_ACK && cpu_rd_q) ? ram_out : cpu_rdata_q;
  assign busy      = (state_q == CLEAR);

endmodule

// File: tb/tb_text_vram_arbiter.sv
// Self-checking bench for text_vram_arbiter: directed scenarios plus randomized CPU/video
// traffic checked against a cell-array model of the visible text grid.
module tb_text_vram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [12:0] vidPos;
  logic [7:0]  character;
  logic [2:0]  fgColor;
  logic [2:0]  bgColor;
  logic        cpuReq;
  logic        cpuWe;
  logic [12:0] cpuAddr;
  logic [13:0] cpuWData;
  logic        cpuAck;
  logic [13:0] cpuRData;
  logic        clrReq;
  logic [13:0] clrData;
  logic        busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [13:0] model [0:8191];
  logic        stepping;

  text_vram_arbiter #(.COLS(80), .ROWS(60), .DATA_W(14)) dut (
    .clk(clk), .reset(reset), .vidPos(vidPos),
    .character(character), .fgColor(fgColor), .bgColor(bgColor),
    .cpuReq(cpuReq), .cpuWe(cpuWe), .cpuAddr(cpuAddr), .cpuWData(cpuWData),
    .cpuAck(cpuAck), .cpuRData(cpuRData),
    .clrReq(clrReq), .clrData(clrData), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #3ms;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic visible(input logic [12:0] a);
    return (a[12:6] < 7'd80) && (a[5:0] < 6'd60);
  endfunction

  function automatic logic [13:0] exp_rd(input logic [12:0] a);
    return visible(a) ? model[a] : 14'h0;
  endfunction

  function automatic logic [12:0] rand_cell();
    return {7'($urandom_range(0, 79)), 6'($urandom_range(0, 59))};
  endfunction

  // Drives one CPU access starting on a fresh cycle; lat counts the request cycle as 1.
  task automatic cpu_op(input logic we, input logic [12:0] addr, input logic [13:0] wdata,
                        input logic chg, input logic [12:0] vid,
                        output logic [13:0] rdata, output int lat);
    logic got;
    @(negedge clk);
    cpuReq = 1'b1; cpuWe = we; cpuAddr = addr; cpuWData = wdata;
    if (chg) vidPos = vid;
    lat = 1;
    got = 1'b0;
    while (!got && lat < 10000) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
      if (cpuAck) got = 1'b1;
    end
    rdata  = cpuRData;
    cpuReq = 1'b0;
    cpuWe  = 1'b0;
    total++;
    if (!got) begin
      bad++;
      $display("[TB] FAIL cpu_ack_timeout addr=%h got_ack=%0d want_ack=1", addr, got);
    end
  endtask

  task automatic test_reset();
    logic [13:0] r;
    int lat;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    cpu_op(1'b1, 13'h0000, 14'h1056, 1'b0, 13'h0, r, lat);
    model[0] = 14'h1056;
    cpu_op(1'b0, 13'h0000, 14'h0, 1'b0, 13'h0, r, lat);
    @(negedge clk);
    reset = 1'b1; vidPos = 13'h0000;
    @(negedge clk);
    total++; if (character !== 8'h0) begin bad++; $display("[TB] FAIL reset_char got=%h want=0", character); end
    total++; if (fgColor !== 3'h0) begin bad++; $display("[TB] FAIL reset_fg got=%h want=0", fgColor); end
    total++; if (bgColor !== 3'h0) begin bad++; $display("[TB] FAIL reset_bg got=%h want=0", bgColor); end
    total++; if (cpuAck !== 1'b0) begin bad++; $display("[TB] FAIL reset_ack got=%b want=0", cpuAck); end
    total++; if (cpuRData !== 14'h0) begin bad++; $display("[TB] FAIL reset_rdata got=%h want=0", cpuRData); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
    reset = 1'b0;
    @(negedge clk);
    total++; if (character !== 8'h0) begin bad++; $display("[TB] FAIL fetch_lag1 got=%h want=0", character); end
    @(negedge clk);
    total++; if (character !== 8'h41) begin bad++; $display("[TB] FAIL fetch_char got=%h want=41", character); end
    total++; if (fgColor !== 3'd2) begin bad++; $display("[TB] FAIL fetch_fg got=%h want=2", fgColor); end
    total++; if (bgColor !== 3'd6) begin bad++; $display("[TB] FAIL fetch_bg got=%h want=6", bgColor); end
  endtask

  task automatic test_cpu_basic();
    logic [13:0] r;
    int lat;
    cpu_op(1'b1, {7'd5, 6'd3}, 14'h0C38, 1'b0, 13'h0, r, lat);
    model[{7'd5, 6'd3}] = 14'h0C38;
    total++; if (lat != 2) begin bad++; $display("[TB] FAIL basic_wr_lat got=%0d want=2", lat); end
    cpu_op(1'b0, {7'd5, 6'd3}, 14'h0, 1'b0, 13'h0, r, lat);
    total++; if (lat != 2) begin bad++; $display("[TB] FAIL basic_rd_lat got=%0d want=2", lat); end
    total++; if (r !== 14'h0C38) begin bad++; $display("[TB] FAIL basic_rd_data got=%h want=0C38", r); end
  endtask

  task automatic test_video_priority();
    logic [13:0] r, w_old;
    int lat;
    cpu_op(1'b1, {7'd1, 6'd1}, 14'h2345, 1'b1, {7'd5, 6'd3}, r, lat);
    model[{7'd1, 6'd1}] = 14'h2345;
    total++; if (lat != 3) begin bad++; $display("[TB] FAIL vidpri_lat got=%0d want=3", lat); end
    total++; if ({character, fgColor, bgColor} !== model[{7'd5, 6'd3}]) begin
      bad++; $display("[TB] FAIL vidpri_glyph got=%h want=%h", {character, fgColor, bgColor}, model[{7'd5, 6'd3}]);
    end
    repeat (10) @(negedge clk);
    w_old = model[{7'd1, 6'd1}];
    cpu_op(1'b1, {7'd1, 6'd1}, 14'h1234, 1'b1, {7'd1, 6'd1}, r, lat);
    model[{7'd1, 6'd1}] = 14'h1234;
    total++; if (lat != 3) begin bad++; $display("[TB] FAIL samecell_lat got=%0d want=3", lat); end
    total++; if ({character, fgColor, bgColor} !== w_old) begin
      bad++; $display("[TB] FAIL samecell_old got=%h want=%h", {character, fgColor, bgColor}, w_old);
    end
    repeat (10) @(negedge clk);
    vidPos = {7'd5, 6'd3};
    repeat (10) @(negedge clk);
    vidPos = {7'd1, 6'd1};
    repeat (3) @(negedge clk);
    total++; if ({character, fgColor, bgColor} !== 14'h1234) begin
      bad++; $display("[TB] FAIL samecell_new got=%h want=1234", {character, fgColor, bgColor});
    end
  endtask

  task automatic test_clear();
    logic [13:0] r;
    logic        got, ack_busy;
    int          busy_cnt, errs, lat;
    logic [12:0] nv;
    got = 1'b0; ack_busy = 1'b0; busy_cnt = 0; r = '0;
    stepping = 1'b1;
    fork
      begin
        while (stepping) begin
          repeat (8) @(negedge clk);
          if (stepping) begin
            nv = rand_cell();
            for (int k = 0; k < 8 && nv == vidPos; k++) nv = rand_cell();
            vidPos = nv;
          end
        end
      end
      begin
        @(negedge clk);
        clrData = 14'h0807; clrReq = 1'b1;
        cpuReq = 1'b1; cpuWe = 1'b0; cpuAddr = {7'd10, 6'd20};
        for (int i = 0; i < 8000 && !got; i++) begin
          @(posedge clk);
          @(negedge clk);
          clrReq = 1'b0;
          if (busy) begin
            busy_cnt++;
            if (busy_cnt == 2000) begin clrReq = 1'b1; clrData = 14'h3333; end
          end
          if (cpuAck) begin
            got = 1'b1;
            if (busy) ack_busy = 1'b1;
            r = cpuRData;
            cpuReq = 1'b0;
          end
        end
        cpuReq = 1'b0;
        stepping = 1'b0;
      end
    join
    clrData = 14'h0;
    for (int i = 0; i < 8192; i++) if (visible(13'(i))) model[i] = 14'h0807;
    total++; if (got !== 1'b1) begin bad++; $display("[TB] FAIL clear_cpu_ack got=%b want=1", got); end
    total++; if (ack_busy !== 1'b0) begin bad++; $display("[TB] FAIL clear_ack_while_busy got=%b want=0", ack_busy); end
    total++; if (busy_cnt < 5480 || busy_cnt > 5492) begin
      bad++; $display("[TB] FAIL clear_busy_len got=%0d want=5480..5492", busy_cnt);
    end
    total++; if (r !== 14'h0807) begin bad++; $display("[TB] FAIL clear_cpu_rdata got=%h want=0807", r); end
    repeat (3) @(negedge clk);
    errs = 0;
    for (int c = 0; c < 80; c++)
      for (int w = 0; w < 60; w++) begin
        cpu_op(1'b0, {7'(c), 6'(w)}, 14'h0, 1'b0, 13'h0, r, lat);
        if (r !== 14'h0807) begin
          if (errs == 0) $display("[TB] first wrong cell col=%0d row=%0d data=%h", c, w, r);
          errs++;
        end
      end
    total++; if (errs != 0) begin bad++; $display("[TB] FAIL clear_readback bad_cells=%0d want=0", errs); end
  endtask

  task automatic test_out_of_range();
    logic [13:0] r;
    int lat;
    cpu_op(1'b1, {7'd80, 6'd0}, 14'h3FFF, 1'b0, 13'h0, r, lat);
    total++; if (lat != 2) begin bad++; $display("[TB] FAIL oor_wr_lat got=%0d want=2", lat); end
    cpu_op(1'b0, {7'd80, 6'd0}, 14'h0, 1'b0, 13'h0, r, lat);
    total++; if (r !== 14'h0) begin bad++; $display("[TB] FAIL oor_col_rd got=%h want=0", r); end
    cpu_op(1'b1, {7'd3, 6'd60}, 14'h3FFF, 1'b0, 13'h0, r, lat);
    cpu_op(1'b0, {7'd3, 6'd60}, 14'h0, 1'b0, 13'h0, r, lat);
    total++; if (r !== 14'h0) begin bad++; $display("[TB] FAIL oor_row_rd got=%h want=0", r); end
    cpu_op(1'b0, {7'd79, 6'd59}, 14'h0, 1'b0, 13'h0, r, lat);
    total++; if (r !== model[{7'd79, 6'd59}]) begin
      bad++; $display("[TB] FAIL last_cell_rd got=%h want=%h", r, model[{7'd79, 6'd59}]);
    end
  endtask

  task automatic test_random();
    logic [13:0] r, shown, wdata, expect_rd;
    logic [12:0] addr, nv;
    logic        we, chg;
    int          lat, last_chg, p;
    shown = exp_rd(vidPos);
    last_chg = cyc;
    for (int n = 0; n < 300; n++) begin
      we = 1'($urandom_range(0, 1));
      p  = $urandom_range(0, 9);
      if (p == 0) addr = {7'($urandom_range(80, 127)), 6'($urandom_range(0, 63))};
      else if (p == 1) addr = {7'($urandom_range(0, 79)), 6'($urandom_range(60, 63))};
      else addr = rand_cell();
      wdata = 14'($urandom);
      chg = (cyc - last_chg >= 12) && ($urandom_range(0, 2) == 0);
      nv = vidPos;
      if (chg) begin
        nv = rand_cell();
        for (int k = 0; k < 8 && nv == vidPos; k++) nv = rand_cell();
        chg = (nv != vidPos);
      end
      if (chg) begin
        shown = exp_rd(nv);
        last_chg = cyc;
      end
      expect_rd = exp_rd(addr);
      cpu_op(we, addr, wdata, chg, nv, r, lat);
      if (we && visible(addr)) model[addr] = wdata;
      total++; if (lat != (chg ? 3 : 2)) begin
        bad++; $display("[TB] FAIL rand_lat n=%0d got=%0d want=%0d", n, lat, chg ? 3 : 2);
      end
      if (!we) begin
        total++; if (r !== expect_rd) begin
          bad++; $display("[TB] FAIL rand_rd n=%0d addr=%h got=%h want=%h", n, addr, r, expect_rd);
        end
      end
      total++; if ({character, fgColor, bgColor} !== shown) begin
        bad++; $display("[TB] FAIL rand_glyph n=%0d got=%h want=%h", n, {character, fgColor, bgColor}, shown);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    logic [13:0] r, held;
    int lat;
    cpu_op(1'b1, {7'd40, 6'd30}, 14'h1ABC, 1'b0, 13'h0, r, lat);
    model[{7'd40, 6'd30}] = 14'h1ABC;
    total++; if (lat != 2) begin bad++; $display("[TB] FAIL b2b_wr_lat got=%0d want=2", lat); end
    cpu_op(1'b0, {7'd40, 6'd30}, 14'h0, 1'b0, 13'h0, held, lat);
    total++; if (lat != 2) begin bad++; $display("[TB] FAIL b2b_rd_lat got=%0d want=2", lat); end
    total++; if (held !== 14'h1ABC) begin bad++; $display("[TB] FAIL b2b_rd_data got=%h want=1ABC", held); end
    cpu_op(1'b1, {7'd41, 6'd30}, 14'h0111, 1'b0, 13'h0, r, lat);
    model[{7'd41, 6'd30}] = 14'h0111;
    total++; if (r !== 14'h1ABC) begin bad++; $display("[TB] FAIL rdata_hold got=%h want=1ABC", r); end
    clrReq = 1'b1; clrData = 14'h2222;
    @(negedge clk);
    clrReq = 1'b0; clrData = 14'h0;
    total++; if (cpuAck !== 1'b0) begin bad++; $display("[TB] FAIL ack_pulse got=%b want=0", cpuAck); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL clr_in_ack_ignored got=%b want=0", busy); end
    repeat (2) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL clr_in_ack_late got=%b want=0", busy); end
  endtask

  task automatic test_reset_mid_clear();
    logic [13:0] r, want;
    int errs, lat, idx;
    repeat (3) @(negedge clk);
    clrReq = 1'b1; clrData = 14'h2A15;
    @(negedge clk);
    clrReq = 1'b0;
    repeat (1000) @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL midclr_busy got=%b want=1", busy); end
    reset = 1'b1;
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL midclr_abort got=%b want=0", busy); end
    reset = 1'b0;
    for (int c = 0; c < 80; c++)
      for (int w = 0; w < 60; w++)
        if (c * 60 + w < 1000) model[{7'(c), 6'(w)}] = 14'h2A15;
    errs = 0;
    for (int c = 0; c < 80; c++)
      for (int w = 0; w < 60; w++) begin
        idx = c * 60 + w;
        want = model[{7'(c), 6'(w)}];
        cpu_op(1'b0, {7'(c), 6'(w)}, 14'h0, 1'b0, 13'h0, r, lat);
        if (r !== want) begin
          if (errs == 0) $display("[TB] first wrong cell index=%0d data=%h", idx, r);
          errs++;
        end
      end
    total++; if (errs != 0) begin bad++; $display("[TB] FAIL midclr_readback bad_cells=%0d want=0", errs); end
  endtask

  initial begin
    reset = 1'b1; vidPos = 13'h0; cpuReq = 1'b0; cpuWe = 1'b0; cpuAddr = 13'h0;
    cpuWData = 14'h0; clrReq = 1'b0; clrData = 14'h0; stepping = 1'b0;
    for (int i = 0; i < 8192; i++) model[i] = 14'h0;
    test_reset();
    test_cpu_basic();
    test_video_priority();
    test_clear();
    test_out_of_range();
    test_random();
    test_back_to_back();
    test_reset_mid_clear();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
